// File: rtl/riscv_icache.sv
// Direct-mapped, read-only instruction cache: zero-wait hits, 128-bit line refill on a miss
// with proc_stall held from the miss-detect cycle through the mem_ready cycle.
module riscv_icache #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 30 - 2 - INDEX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       data_q [LINES];

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_word;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               miss;
    logic               fill;
    logic               unused_inputs;

    assign req_word  = proc_addr[1:0];
    assign req_index = proc_addr[INDEX_W+1:2];
    assign req_tag   = proc_addr[29:INDEX_W+2];

    // The fill targets the latched miss address, so a wandering proc_addr cannot redirect it.
    assign fill_index = mem_addr[INDEX_W-1:0];
    assign fill_tag   = mem_addr[27:INDEX_W];

    assign hit        = proc_read && valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign proc_rdata = data_q[req_index][{req_word, 5'd0} +: 32];

    assign mem_write     = 1'b0;
    assign mem_wdata     = '0;
    assign unused_inputs = ^{proc_write, proc_wdata};

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        miss       = 1'b0;
        fill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (proc_read && !hit) begin
                    miss       = 1'b1;
                    proc_stall = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= '0;
            mem_addr <= '0;
        end else begin
            state_q <= state_d;
            if (miss) mem_addr <= proc_addr[29:2];
            if (fill) valid_q[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately left unreset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_riscv_icache.sv
// Self-checking bench for riscv_icache: directed test-plan steps followed by randomized
// accesses, all checked against a line-level cache model kept in the bench.
module tb_riscv_icache;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what each of the 8 lines currently holds.
    bit           m_valid [8];
    logic [24:0]  m_tag   [8];
    logic [127:0] m_line  [8];

    riscv_icache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] k);
        return line[32*k +: 32];
    endfunction

    // Backing-memory contents: every word distinct and derived from its line address.
    function automatic logic [127:0] gen_line(input logic [27:0] line_addr);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = {2'b10, line_addr, 2'(k)} ^ 32'h5A00_0000;
        return l;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // One read request; a miss is answered after 'lat' FETCH cycles with 'line'.
    task automatic read_access(input logic [29:0] addr, input logic [127:0] line,
                               input int lat, input bit noise);
        int          idx;
        logic [24:0] tg;
        bit          exp_hit;
        idx     = int'(addr[4:2]);
        tg      = addr[29:5];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = addr;
        mem_ready = noise;
        mem_rdata = {4{$urandom}};
        #1;
        check("detect_stall", proc_stall, !exp_hit);
        check("detect_mem_read", mem_read, 1'b0);
        if (exp_hit) begin
            check("hit_rdata", proc_rdata, word_of(m_line[idx], addr[1:0]));
        end else begin
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                mem_ready = (c == lat);
                mem_rdata = (c == lat) ? line : ~line;
                #1;
                check("fetch_stall", proc_stall, 1'b1);
                check("fetch_mem_read", mem_read, 1'b1);
                check("fetch_mem_addr", mem_addr, addr[29:2]);
            end
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_line[idx]  = line;
            check("refill_stall", proc_stall, 1'b0);
            check("refill_mem_read", mem_read, 1'b0);
            check("refill_rdata", proc_rdata, word_of(line, addr[1:0]));
        end
    endtask

    initial begin
        logic [29:0] a;
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", proc_stall, 1'b0);
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_mem_addr", mem_addr, 28'h0);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("idle_stall", proc_stall, 1'b0);
            check("idle_mem_read", mem_read, 1'b0);
            check("idle_mem_write", mem_write, 1'b0);
            check("idle_mem_wdata", mem_wdata, 128'h0);
        end

        // Cold miss, then hits on all four offsets.
        read_access(30'h4, 128'h44444444_33333333_22222222_11111111, 3, 1'b0);
        for (int i = 0; i < 4; i++) read_access(30'h4 + 30'(i), '0, 1, 1'b0);
        check("cold_word3", proc_rdata, 32'h44444444);

        // Conflict eviction on index 1.
        read_access(30'h24, gen_line(28'h9), 2, 1'b0);
        read_access(30'h25, '0, 1, 1'b0);
        read_access(30'h4, gen_line(28'h1), 1, 1'b0);

        // Reset asserted mid-FETCH; the late mem_ready must not fill.
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h8;
        mem_ready = 1'b0;
        #1;
        check("rst_detect_stall", proc_stall, 1'b1);
        @(negedge clk);
        #1;
        check("rst_fetch_mem_read", mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_read_drop", mem_read, 1'b0);
        clear_model();
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = gen_line(28'h2);
        @(negedge clk);
        rst_n     = 1'b1;
        proc_read = 1'b0;
        #1;
        check("rst_ignored_stall", proc_stall, 1'b0);
        check("rst_ignored_mem_read", mem_read, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        read_access(30'h8, gen_line(28'h2), 2, 1'b0);
        read_access(30'h4, gen_line(28'h1), 1, 1'b0);

        // Writes never fetch or alter the cache, with or without a concurrent read.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            proc_read  = 1'b0;
            proc_write = 1'b1;
            proc_addr  = (i % 2 == 0) ? 30'h8 : 30'h30;
            proc_wdata = $urandom;
            mem_ready  = 1'b0;
            #1;
            check("write_stall", proc_stall, 1'b0);
            check("write_mem_read", mem_read, 1'b0);
            check("write_mem_write", mem_write, 1'b0);
        end
        read_access(30'h9, '0, 1, 1'b0);
        proc_write = 1'b0;
        read_access(30'hA, '0, 1, 1'b0);

        // Randomized traffic over a small tag set so hits, misses and evictions mix.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                proc_read = 1'b0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = {4{$urandom}};
                #1;
                check("rand_idle_stall", proc_stall, 1'b0);
                check("rand_idle_mem_read", mem_read, 1'b0);
            end else begin
                a = {25'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                read_access(a, gen_line(a[29:2]), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_icache.md
# riscv_icache

Direct-mapped, read-only instruction cache between the IF stage and the slow instruction memory. It serves word reads on the IF stage's ICACHE port (read-enable, write-enable, word address, read data, write data, stall) and refills 128-bit lines from memory on a miss. It raises a stall to freeze the PC for the whole miss. Hits return data combinationally with zero wait cycles.

## Interface
Parameters:
- INDEX_W, 3: index bits; line count = 2^INDEX_W.
- TAG_W, 30-2-INDEX_W: tag bits, derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- proc_read  in  1  read request from IF.
- proc_write  in  1  write request; ignored (read-only cache).
- proc_addr  in  30  word address; [1:0] word-in-line, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- proc_wdata  in  32  unused.
- proc_rdata  out  32  selected word, unmodified byte order.
- proc_stall  out  1  request not yet served; IF holds its PC.
- mem_read  out  1  line read request to memory.
- mem_write  out  1  constant 0.
- mem_addr  out  28  line address (proc_addr[29:2] of the missing request).
- mem_wdata  out  128  constant 0.
- mem_rdata  in  128  line data; word k = mem_rdata[32k+31:32k].
- mem_ready  in  1  one-cycle pulse, mem_rdata valid this cycle.

## Operation
- Storage per line: valid bit, TAG_W tag, 128-bit data.
- Hit = proc_read & valid[index] & tag[index]==proc_addr tag.
- FSM states: IDLE and FETCH.
- IDLE, proc_read=0: proc_stall=0, no memory activity.
- IDLE, hit: proc_stall=0; proc_rdata = word proc_addr[1:0] of line[index].
- IDLE, miss: proc_stall=1; latch proc_addr[29:2] into mem_addr; next state FETCH.
- FETCH: mem_read=1, proc_stall=1.
  - On the mem_ready cycle, at the edge: line[index] data <= mem_rdata, tag written, valid <= 1, next state IDLE.
  - Index and tag for the fill come from the latched mem_addr, not the live proc_addr.
- After a refill the re-presented request hits in IDLE.
- proc_write is ignored in all states, whether or not proc_read is also high. It never alters tags, data or valid bits and never starts a fetch.
- proc_rdata is defined only when proc_read=1 and proc_stall=0. Otherwise it is the indexed word and must not be relied on.
- A refill replaces the indexed line unconditionally; no dirty state and no write-back.
- Reset: all valid bits 0, state IDLE, mem_read 0, mem_addr 0. Data and tag arrays need no reset.

## Timing
- Hit latency: 0 cycles; proc_rdata is valid in the same cycle, proc_stall=0.
- Miss: proc_stall is high from the miss-detect cycle through the mem_ready cycle.
  - Stall cycles = 1 + F, where F = FETCH cycles including the mem_ready cycle.
  - The cycle after mem_ready returns to IDLE with a hit and stall=0.
- mem_read rises the cycle after miss detection. It stays high through the mem_ready cycle and is low the following cycle.
- mem_addr is stable for the whole FETCH.
- proc_addr is required stable while proc_stall=1, because IF holds the PC. A change during FETCH does not redirect the fill.
- A mem_ready seen in IDLE is ignored.
- Reset asserted mid-FETCH: immediately mem_read=0, state IDLE, all lines invalid. The in-flight line is discarded, and a later mem_ready is ignored.
- The first read after reset always misses.

## Test plan
- Cold miss: reset, proc_read=1, proc_addr=0x0000004, memory returns 0x44444444_33333333_22222222_11111111 after 3 FETCH cycles.
  - Required: stall high 4 cycles, mem_addr=0x0000001, mem_read high 3 cycles.
  - Next cycle: proc_rdata=0x11111111, stall=0.
- Hit, all offsets: after the fill, proc_addr 0x4 to 0x7 on consecutive cycles.
  - Required: rdata 0x11111111, 0x22222222, 0x33333333, 0x44444444; stall 0 every cycle; mem_read never asserted.
- Conflict eviction: fill addr 0x4, then read 0x24 (same index, different tag).
  - Required: miss, mem_addr=0x0000009, line replaced.
  - Reading 0x4 again misses.
- Reset mid-fetch: miss on 0x8, assert rst_n=0 during FETCH, then pulse mem_ready.
  - Required: mem_read drops with reset, the ignored mem_ready causes no fill, and the next read of 0x8 misses.
- Writes ignored: proc_write=1, proc_read=0 at a cached address.
  - Required: stall 0, no mem activity, the later read still hits with the original data.
- Idle: proc_read=0 for 10 cycles after reset.
  - Required: stall 0, mem_read 0, mem_write 0, mem_wdata 0 throughout.
